sm4_round_state_ctrl: RTL
=========================

// Module: sm4_round_state_ctrl
// PURPOSE
//   Parametrised round-state register and sequencer for iterative block ciphers.
//   - Loads an initial block through a valid/ready handshake.
//   - Feeds the registered state to an external combinational round function.
//   - Writes the round result back each cycle for ROUNDS cycles.
//   - Presents the result, optionally word-reversed (SM4 final R transform), through an output valid/ready handshake.
//   - Sits between the SM4 input interface and the round/key-schedule datapath.
// PARAMETERS
//   DATA_W      128  block width in bits; must be a multiple of WORD_W
//   WORD_W      32   word width used by the output reversal
//   ROUNDS      32   round iterations per block; must be >= 1
//   CNT_W       6    round counter width; must satisfy 2**CNT_W >= ROUNDS
//   REVERSE_OUT 1    1: out_data = state with word order reversed; 0: state passes through unchanged
// PORTS
//   clk         in   1       clock, rising edge
//   rest        in   1       asynchronous active-low reset
//   abort       in   1       synchronous cancel; returns FSM to IDLE
//   in_valid    in   1       initial block offered
//   in_ready    out  1       block controller can accept in_data
//   in_data     in   DATA_W  initial block
//   round_data  in   DATA_W  round function result computed from state_q and round_cnt
//   state_q     out  DATA_W  registered state, drives the round function
//   round_cnt   out  CNT_W   current round index, used to select the round key
//   busy        out  1       high in RUN
//   out_valid   out  1       result available
//   out_ready   in   1       consumer accepts result
//   out_data    out  DATA_W  final block
// BEHAVIOUR
//   Reset (rest=0, asynchronous): FSM=IDLE, state_q=0, round_cnt=0; busy=0, out_valid=0.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: in_ready=1. On in_valid, at the clock edge: state_q<=in_data, round_cnt<=0, go to RUN.
//     RUN: in_ready=0, busy=1. Every cycle: state_q<=round_data.
//       - If round_cnt != ROUNDS-1: round_cnt<=round_cnt+1.
//       - If round_cnt == ROUNDS-1: round_cnt holds; go to DONE.
//     DONE: out_valid=1. state_q and round_cnt hold until out_ready=1.
//       - out_ready=1 and in_valid=0: go to IDLE.
//       - out_ready=1 and in_valid=1 in the same cycle: back-to-back load; state_q<=in_data, round_cnt<=0, go to RUN.
//   in_ready = (FSM==IDLE) | (FSM==DONE & out_ready); purely combinational.
//   out_data: combinational from state_q.
//     - REVERSE_OUT=1: word i of out_data = word (N-1-i) of state_q, with N = DATA_W/WORD_W.
//     - Driven in every state; meaningful only while out_valid=1.
//   Latency: ROUNDS clock edges from the accepting in-handshake edge to out_valid high.
//     Throughput: one block per ROUNDS+1 cycles with a continuous consumer.
//   ROUNDS=1: a single RUN cycle, then DONE.
//   abort=1 (synchronous): FSM<=IDLE, round_cnt<=0, out_valid drops next cycle.
//     - state_q is not cleared.
//     - abort takes priority over any load or round update in the same cycle.
//   Reset asserted mid-RUN or in DONE: immediate return to reset values; the pending result is lost.
//   in_valid while busy: ignored, because in_ready=0; the source must hold its data.
//   out_valid stays high and out_data stays stable until the handshake completes.
// TESTING (bench uses stub round function round_data = state_q + 1, defaults)
//   1. Reset: assert rest=0 mid-RUN -> next sample shows busy=0, out_valid=0, round_cnt=0, state_q=0.
//   2. Single block: in_data=0, in_valid pulse -> out_valid high exactly 32 edges later;
//      out_data = 128'h00000020_00000000_00000000_00000000.
//   3. REVERSE_OUT=0, in_data=128'h10 -> out_data=128'h30; round_cnt visits 0..31, each value for 1 cycle.
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable;
//      in_ready=0 and in_valid ignored.
//   5. Back-to-back: out_ready=1 and in_valid=1 (in_data=128'h5) in the DONE cycle ->
//      no IDLE cycle; next result 128'h25 (unreversed) 32 edges later.
//   6. Abort at round_cnt=7 -> IDLE next cycle, in_ready=1, out_valid never asserts;
//      a following block completes normally.

Source files
------------

// File: rtl/sm4_round_state_ctrl.sv
// Round-state register and sequencer for iterative block ciphers: loads a block,
// iterates an external round function ROUNDS times, then offers the (optionally word-reversed) result.
module sm4_round_state_ctrl #(
   parameter int DATA_W      = 128,
   parameter int WORD_W      = 32,
   parameter int ROUNDS      = 32,
   parameter int CNT_W       = 6,
   parameter int REVERSE_OUT = 1
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] round_data,
   output logic [DATA_W-1:0] state_q,
   output logic [CNT_W-1:0]  round_cnt,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam int             N_WORDS  = DATA_W / WORD_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } fsm_t;

   fsm_t              fsm_reg, fsm_next;
   logic [DATA_W-1:0] state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         fsm_reg   <= ST_IDLE;
         state_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         fsm_reg   <= fsm_next;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // abort outranks both a fresh load and the round write-back; state is kept on abort
   always_comb begin
      fsm_next   = fsm_reg;
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (abort) begin
         fsm_next = ST_IDLE;
         cnt_next = '0;
      end else begin
         unique case (fsm_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  state_next = in_data;
                  cnt_next   = '0;
                  fsm_next   = ST_RUN;
               end
            end
            ST_RUN: begin
               state_next = round_data;
               if (cnt_reg == LAST_CNT) begin
                  fsm_next = ST_DONE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  if (in_valid) begin
                     state_next = in_data;
                     cnt_next   = '0;
                     fsm_next   = ST_RUN;
                  end else begin
                     fsm_next = ST_IDLE;
                  end
               end
            end
            default: fsm_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      unique case (fsm_reg)
         ST_IDLE: in_ready = 1'b1;
         ST_RUN:  busy = 1'b1;
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   assign state_q   = state_reg;
   assign round_cnt = cnt_reg;

   generate
      if (REVERSE_OUT != 0) begin : g_rev
         for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
            assign out_data[gi*WORD_W +: WORD_W] = state_reg[(N_WORDS-1-gi)*WORD_W +: WORD_W];
         end
      end else begin : g_fwd
         assign out_data = state_reg;
      end
   endgenerate

endmodule
